multicycle_controller: RTL and testbench
========================================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 The block SHALL have parameter MEM_TIMEOUT, default 15: maximum wait cycles for mem_ready in any memory state (range 1..255).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port opcode, input, 3 bits: instruction register bits [7:5].
REQ-005 The block SHALL have port czn, input, 3 bits: ALU flags, where [0] is carry, [1] is zero and [2] is negative.
REQ-006 The block SHALL have port mem_ready, input, 1 bit: memory has completed the current read or write.
REQ-007 The block SHALL have ports mem_read and mem_write, outputs, 1 bit each: memory strobes.
REQ-008 The block SHALL have port addr_sel, output, 1 bit: 0 selects PC as the memory address, 1 selects the IR operand.
REQ-009 The block SHALL have ports ir_write, mdr_write, pc_inc, pc_load and acc_write, outputs, 1 bit each: register load enables.
REQ-010 The block SHALL have port acc_src, output, 1 bit: 0 selects the ALU result, 1 selects MDR.
REQ-011 The block SHALL have port alu_op, output, 2 bits: 00 = ADD, 01 = AND, 10 = OR.
REQ-012 The block SHALL have port alu_cin, output, 1 bit: ALU carry-in.
REQ-013 The block SHALL have port flags, output, 3 bits: registered {N, Z, C}.
REQ-014 The block SHALL have ports state, output, 4 bits (debug), and error, output, 1 bit.

Function
REQ-015 Opcode decode SHALL be: 000 ADD, 001 ADC, 010 AND, 011 OR, 100 LDA, 101 STA, 110 JMP, 111 JZ.
REQ-016 The states SHALL be INIT=0, FETCH=1, DECODE=2, OPERAND=3, EXEC=4, LOAD=5, STORE=6, JUMP=7, ERROR=8, with state output equal to this encoding.
REQ-017 All outputs SHALL be Moore-decoded from the current state, except ir_write, pc_inc and mdr_write, which also require mem_ready; every output not named for a state SHALL be 0.
REQ-018 INIT SHALL drive all strobes 0 and go to FETCH unconditionally.
REQ-019 FETCH SHALL drive mem_read=1 and addr_sel=0; on mem_ready it SHALL pulse ir_write=1 and pc_inc=1 and go to DECODE, otherwise it SHALL stay in FETCH.
REQ-020 DECODE SHALL drive no strobes and go to OPERAND for opcodes 000–100, STORE for 101, and JUMP for 110.
REQ-021 For opcode 111, DECODE SHALL go to JUMP if flags Z=1 and to FETCH otherwise.
REQ-022 OPERAND SHALL drive mem_read=1 and addr_sel=1; on mem_ready it SHALL pulse mdr_write=1 and go to LOAD for LDA and to EXEC otherwise.
REQ-023 EXEC SHALL drive acc_write=1, acc_src=0 and alu_op per opcode, with alu_cin = C for ADC and 0 otherwise, then go to FETCH.
REQ-024 In EXEC, ADD/ADC SHALL load C, Z and N from czn; AND/OR SHALL load Z and N only, leaving C unchanged.
REQ-025 LOAD SHALL drive acc_write=1 and acc_src=1, leave flags unchanged, and go to FETCH.
REQ-026 STORE SHALL drive mem_write=1 and addr_sel=1; it SHALL go to FETCH on mem_ready and stay otherwise.
REQ-027 JUMP SHALL drive pc_load=1 and go to FETCH.
REQ-028 A wait counter SHALL clear on entry to FETCH, OPERAND or STORE and increment each cycle mem_ready=0 in those states.
REQ-029 When the wait counter equals MEM_TIMEOUT with mem_ready still 0, the next state SHALL be ERROR; if mem_ready=1 in that same cycle, the normal transition SHALL take priority.
REQ-030 ERROR SHALL drive error=1 with all strobes 0 and SHALL be left only by reset.
REQ-031 Zero-wait latencies SHALL be: ALU ops and LDA 4 cycles; STA 3; JMP and taken JZ 3; not-taken JZ 2.
REQ-032 An undefined state encoding SHALL go to ERROR.

Reset
REQ-033 While rst=0, the block SHALL immediately hold state=INIT, flags=000, wait counter=0, error=0 and all strobes 0, regardless of clk.
REQ-034 Reset asserted mid-instruction, including during a memory wait, SHALL abort the instruction without further strobes.
REQ-035 After rst deasserts, the first rising edge SHALL enter FETCH.

Verification
REQ-036 Bench SHALL cover ADC, flags C=1, opcode=001, zero-wait memory → alu_cin=1 in EXEC, acc_write=1, FETCH reached 4 cycles after the previous FETCH exit.
REQ-037 Bench SHALL cover ADD with czn=001, then OR with czn=010 → flags=001, then flags=011 (C retained).
REQ-038 Bench SHALL cover JZ with Z=0 → DECODE→FETCH, pc_load never asserted; JZ with Z=1 → one-cycle pc_load=1.
REQ-039 Bench SHALL cover STA with mem_ready held 0 for 3 cycles → mem_write=1 for 4 cycles, then FETCH; MEM_TIMEOUT=2 with mem_ready stuck 0 in FETCH → ERROR after 3 cycles, error=1.
REQ-040 Bench SHALL cover rst=0 asserted asynchronously mid-OPERAND → state=0 and mem_read=0 before the next clk edge.

Source files
------------

// File: rtl/multicycle_controller.sv
// Control unit for a simple accumulator CPU: a Moore FSM with a memory-wait
// timeout. It drives the datapath strobes and holds the N/Z/C flag register.
module multicycle_controller #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] opcode,
  input  logic [2:0] czn,
  input  logic       mem_ready,
  output logic       mem_read,
  output logic       mem_write,
  output logic       addr_sel,
  output logic       ir_write,
  output logic       mdr_write,
  output logic       pc_inc,
  output logic       pc_load,
  output logic       acc_write,
  output logic       acc_src,
  output logic [1:0] alu_op,
  output logic       alu_cin,
  output logic [2:0] flags,
  output logic [3:0] state,
  output logic       error
);

  localparam logic [3:0] S_INIT    = 4'd0;
  localparam logic [3:0] S_FETCH   = 4'd1;
  localparam logic [3:0] S_DECODE  = 4'd2;
  localparam logic [3:0] S_OPERAND = 4'd3;
  localparam logic [3:0] S_EXEC    = 4'd4;
  localparam logic [3:0] S_LOAD    = 4'd5;
  localparam logic [3:0] S_STORE   = 4'd6;
  localparam logic [3:0] S_JUMP    = 4'd7;
  localparam logic [3:0] S_ERROR   = 4'd8;

  localparam logic [7:0] TIMEOUT = MEM_TIMEOUT[7:0];

  logic [3:0] next_state;
  logic [7:0] wait_cnt;
  logic       timeout;
  logic       mem_now;
  logic       mem_next;

  function automatic logic is_mem(input logic [3:0] s);
    return (s == S_FETCH) || (s == S_OPERAND) || (s == S_STORE);
  endfunction

  assign timeout  = (wait_cnt == TIMEOUT) && !mem_ready;
  assign mem_now  = is_mem(state);
  assign mem_next = is_mem(next_state);

  // A ready memory wins over a timeout reached in the same cycle.
  always_comb begin
    next_state = state;
    case (state)
      S_INIT:    next_state = S_FETCH;
      S_FETCH: begin
        if (mem_ready)    next_state = S_DECODE;
        else if (timeout) next_state = S_ERROR;
      end
      S_DECODE: begin
        case (opcode)
          3'b101:  next_state = S_STORE;
          3'b110:  next_state = S_JUMP;
          3'b111:  next_state = flags[1] ? S_JUMP : S_FETCH;
          default: next_state = S_OPERAND;
        endcase
      end
      S_OPERAND: begin
        if (mem_ready)    next_state = (opcode == 3'b100) ? S_LOAD : S_EXEC;
        else if (timeout) next_state = S_ERROR;
      end
      S_EXEC:    next_state = S_FETCH;
      S_LOAD:    next_state = S_FETCH;
      S_STORE: begin
        if (mem_ready)    next_state = S_FETCH;
        else if (timeout) next_state = S_ERROR;
      end
      S_JUMP:    next_state = S_FETCH;
      S_ERROR:   next_state = S_ERROR;
      default:   next_state = S_ERROR;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_INIT;
      wait_cnt <= '0;
      flags    <= '0;
    end else begin
      state <= next_state;

      if (mem_next && (next_state != state))
        wait_cnt <= '0;
      else if (mem_now && !mem_ready)
        wait_cnt <= wait_cnt + 8'd1;

      // Logical ops leave carry alone; arithmetic ops load all three flags.
      if (state == S_EXEC) begin
        case (opcode)
          3'b000, 3'b001: flags <= czn;
          3'b010, 3'b011: flags <= {czn[2], czn[1], flags[0]};
          default:        flags <= flags;
        endcase
      end
    end
  end

  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    addr_sel  = 1'b0;
    ir_write  = 1'b0;
    mdr_write = 1'b0;
    pc_inc    = 1'b0;
    pc_load   = 1'b0;
    acc_write = 1'b0;
    acc_src   = 1'b0;
    alu_op    = 2'b00;
    alu_cin   = 1'b0;
    error     = 1'b0;
    case (state)
      S_FETCH: begin
        mem_read = 1'b1;
        ir_write = mem_ready;
        pc_inc   = mem_ready;
      end
      S_OPERAND: begin
        mem_read  = 1'b1;
        addr_sel  = 1'b1;
        mdr_write = mem_ready;
      end
      S_EXEC: begin
        acc_write = 1'b1;
        case (opcode)
          3'b010:  alu_op = 2'b01;
          3'b011:  alu_op = 2'b10;
          default: alu_op = 2'b00;
        endcase
        alu_cin = (opcode == 3'b001) && flags[0];
      end
      S_LOAD: begin
        acc_write = 1'b1;
        acc_src   = 1'b1;
      end
      S_STORE: begin
        mem_write = 1'b1;
        addr_sel  = 1'b1;
      end
      S_JUMP:  pc_load = 1'b1;
      S_ERROR: error   = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: hand-computed instruction
// table, randomized instructions against a transaction-level model, corner sequences.
module tb_multicycle_controller;

  typedef struct {
    logic [2:0] op;
    logic [2:0] cz;
    int         fw;
    int         mw;
    int         exp_cyc;
    logic [2:0] exp_flags;
    int         exp_acc;
    int         exp_pcl;
    int         exp_memw;
    int         exp_cin;
  } vec_t;

  typedef struct {
    int cyc;
    int acc;
    int pcl;
    int memw;
    int memr;
    int irw;
    int pci;
    int mdrw;
    int addr;
    int err;
    int cin;
    int aluop;
    int src;
    int hung;
  } obs_t;

  logic       clk;
  logic       rst;
  logic [2:0] opcode;
  logic [2:0] czn;
  logic       mem_ready;
  logic       mem_read, mem_write, addr_sel, ir_write, mdr_write, pc_inc, pc_load;
  logic       acc_write, acc_src, alu_cin, error;
  logic [1:0] alu_op;
  logic [2:0] flags;
  logic [3:0] state;

  logic       rst_t;
  logic [2:0] opcode_t;
  logic [2:0] czn_t;
  logic       mem_ready_t;
  logic       mem_read_t, mem_write_t, addr_sel_t, ir_write_t, mdr_write_t, pc_inc_t, pc_load_t;
  logic       acc_write_t, acc_src_t, alu_cin_t, error_t;
  logic [1:0] alu_op_t;
  logic [2:0] flags_t;
  logic [3:0] state_t;

  int         checks = 0;
  int         errors = 0;
  logic [2:0] model_flags;
  vec_t       tv[10];

  multicycle_controller dut (
    .clk(clk), .rst(rst), .opcode(opcode), .czn(czn), .mem_ready(mem_ready),
    .mem_read(mem_read), .mem_write(mem_write), .addr_sel(addr_sel),
    .ir_write(ir_write), .mdr_write(mdr_write), .pc_inc(pc_inc), .pc_load(pc_load),
    .acc_write(acc_write), .acc_src(acc_src), .alu_op(alu_op), .alu_cin(alu_cin),
    .flags(flags), .state(state), .error(error)
  );

  multicycle_controller #(.MEM_TIMEOUT(2)) dut_t (
    .clk(clk), .rst(rst_t), .opcode(opcode_t), .czn(czn_t), .mem_ready(mem_ready_t),
    .mem_read(mem_read_t), .mem_write(mem_write_t), .addr_sel(addr_sel_t),
    .ir_write(ir_write_t), .mdr_write(mdr_write_t), .pc_inc(pc_inc_t), .pc_load(pc_load_t),
    .acc_write(acc_write_t), .acc_src(acc_src_t), .alu_op(alu_op_t), .alu_cin(alu_cin_t),
    .flags(flags_t), .state(state_t), .error(error_t)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int strobes_main();
    return int'({mem_read, mem_write, addr_sel, ir_write, mdr_write, pc_inc, pc_load,
                 acc_write, acc_src, alu_op, alu_cin});
  endfunction

  function automatic int strobes_t();
    return int'({mem_read_t, mem_write_t, addr_sel_t, ir_write_t, mdr_write_t, pc_inc_t,
                 pc_load_t, acc_write_t, acc_src_t, alu_op_t, alu_cin_t});
  endfunction

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Runs one instruction from FETCH back to FETCH; fw/mw are memory wait cycles.
  task automatic applyStimulus(input logic [2:0] op, input logic [2:0] cz,
                               input int fw, input int mw, output obs_t o);
    int         left;
    logic [3:0] prev;
    bit         away;
    o = '{default: 0};
    o.hung = 1;
    opcode = op;
    czn    = cz;
    left   = fw;
    prev   = 4'd1;
    away   = 1'b0;
    for (int k = 0; k < 64; k++) begin
      if (state != prev) begin
        prev = state;
        if (state == 4'd3 || state == 4'd6) left = mw;
      end
      if (state == 4'd1 || state == 4'd3 || state == 4'd6) begin
        mem_ready = (left == 0);
        if (left > 0) left--;
      end else begin
        mem_ready = 1'($urandom_range(0, 1));
      end
      #1;
      o.memr += int'(mem_read);
      o.memw += int'(mem_write);
      o.addr += int'(addr_sel);
      o.irw  += int'(ir_write);
      o.pci  += int'(pc_inc);
      o.mdrw += int'(mdr_write);
      o.pcl  += int'(pc_load);
      o.acc  += int'(acc_write);
      o.err  += int'(error);
      if (acc_write) begin
        o.cin   = int'(alu_cin);
        o.aluop = int'(alu_op);
        o.src   = int'(acc_src);
      end
      @(posedge clk);
      o.cyc++;
      @(negedge clk);
      if (state != 4'd1) away = 1'b1;
      if (state == 4'd8) break;
      if (away && state == 4'd1) begin
        o.hung = 0;
        break;
      end
    end
  endtask

  initial begin
    obs_t o;
    // {op, czn, fetch wait, mem wait, cycles, flags after, acc, pc_load, mem_write, cin}
    tv[0] = '{3'b000, 3'b001, 0, 0, 4, 3'b001, 1, 0, 0, 0};
    tv[1] = '{3'b011, 3'b010, 0, 0, 4, 3'b011, 1, 0, 0, 0};
    tv[2] = '{3'b001, 3'b000, 0, 0, 4, 3'b000, 1, 0, 0, 1};
    tv[3] = '{3'b111, 3'b101, 0, 0, 2, 3'b000, 0, 0, 0, 0};
    tv[4] = '{3'b010, 3'b110, 1, 0, 5, 3'b110, 1, 0, 0, 0};
    tv[5] = '{3'b111, 3'b000, 0, 0, 3, 3'b110, 0, 1, 0, 0};
    tv[6] = '{3'b101, 3'b000, 0, 3, 6, 3'b110, 0, 0, 4, 0};
    tv[7] = '{3'b100, 3'b111, 0, 2, 6, 3'b110, 1, 0, 0, 0};
    tv[8] = '{3'b110, 3'b000, 2, 0, 5, 3'b110, 0, 1, 0, 0};
    tv[9] = '{3'b001, 3'b011, 0, 0, 4, 3'b011, 1, 0, 0, 0};

    rst = 1'b0; opcode = 3'b000; czn = 3'b000; mem_ready = 1'b0;
    rst_t = 1'b0; opcode_t = 3'b110; czn_t = 3'b000; mem_ready_t = 1'b0;
    model_flags = 3'b000;

    #2;
    checkOutput("reset_state", int'(state), 0);
    checkOutput("reset_flags", int'(flags), 0);
    checkOutput("reset_error", int'(error), 0);
    checkOutput("reset_strobes", strobes_main(), 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("first_edge_fetch", int'(state), 1);

    for (int i = 0; i < 10; i++) begin
      applyStimulus(tv[i].op, tv[i].cz, tv[i].fw, tv[i].mw, o);
      checkOutput($sformatf("vec%0d_return", i), o.hung, 0);
      checkOutput($sformatf("vec%0d_cycles", i), o.cyc, tv[i].exp_cyc);
      checkOutput($sformatf("vec%0d_flags", i), int'(flags), int'(tv[i].exp_flags));
      checkOutput($sformatf("vec%0d_acc_write", i), o.acc, tv[i].exp_acc);
      checkOutput($sformatf("vec%0d_pc_load", i), o.pcl, tv[i].exp_pcl);
      checkOutput($sformatf("vec%0d_mem_write", i), o.memw, tv[i].exp_memw);
      checkOutput($sformatf("vec%0d_alu_cin", i), o.cin, tv[i].exp_cin);
      model_flags = tv[i].exp_flags;
    end

    for (int i = 0; i < 40; i++) begin
      logic [2:0] op, cz;
      int fw, mw, lat, e_aluop;
      bit uses_operand, is_sta, taken, jumps;
      op = 3'($urandom_range(0, 7));
      cz = 3'($urandom_range(0, 7));
      fw = $urandom_range(0, 3);
      mw = $urandom_range(0, 3);
      uses_operand = (op <= 3'd4);
      is_sta = (op == 3'd5);
      taken  = (op == 3'd7) && model_flags[1];
      jumps  = (op == 3'd6) || taken;
      lat = uses_operand ? 4 : ((is_sta || jumps) ? 3 : 2);
      e_aluop = (op == 3'd2) ? 1 : ((op == 3'd3) ? 2 : 0);

      applyStimulus(op, cz, fw, mw, o);
      checkOutput("rnd_return", o.hung, 0);
      checkOutput("rnd_cycles", o.cyc, lat + fw + ((uses_operand || is_sta) ? mw : 0));
      checkOutput("rnd_mem_read", o.memr, fw + 1 + (uses_operand ? mw + 1 : 0));
      checkOutput("rnd_mem_write", o.memw, is_sta ? mw + 1 : 0);
      checkOutput("rnd_addr_sel", o.addr, (uses_operand || is_sta) ? mw + 1 : 0);
      checkOutput("rnd_ir_write", o.irw, 1);
      checkOutput("rnd_pc_inc", o.pci, 1);
      checkOutput("rnd_mdr_write", o.mdrw, uses_operand ? 1 : 0);
      checkOutput("rnd_acc_write", o.acc, uses_operand ? 1 : 0);
      checkOutput("rnd_pc_load", o.pcl, jumps ? 1 : 0);
      checkOutput("rnd_error", o.err, 0);
      checkOutput("rnd_alu_cin", o.cin, (op == 3'd1) ? int'(model_flags[0]) : 0);
      if (uses_operand) begin
        checkOutput("rnd_acc_src", o.src, (op == 3'd4) ? 1 : 0);
        if (op != 3'd4) checkOutput("rnd_alu_op", o.aluop, e_aluop);
      end
      if (op <= 3'd1) model_flags = cz;
      else if (op <= 3'd3) model_flags = {cz[2], cz[1], model_flags[0]};
      checkOutput("rnd_flags", int'(flags), int'(model_flags));
    end

    // Asynchronous reset while OPERAND is waiting on memory.
    opcode = 3'b000; czn = 3'b000; mem_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mem_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("midop_state", int'(state), 3);
    @(posedge clk);
    @(negedge clk);
    #1;
    checkOutput("midop_mem_read", int'(mem_read), 1);
    rst = 1'b0;
    #1;
    checkOutput("async_rst_state", int'(state), 0);
    checkOutput("async_rst_mem_read", int'(mem_read), 0);
    checkOutput("async_rst_flags", int'(flags), 0);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      checkOutput("rst_hold_state", int'(state), 0);
      checkOutput("rst_hold_strobes", strobes_main(), 0);
    end
    @(negedge clk);
    rst = 1'b1;
    model_flags = 3'b000;
    @(posedge clk);
    @(negedge clk);
    checkOutput("rerelease_fetch", int'(state), 1);
    checkOutput("rerelease_error", int'(error), 0);

    // Timeout instance: memory never answers in FETCH.
    begin
      int n;
      n = 0;
      @(negedge clk);
      rst_t = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checkOutput("to_fetch", int'(state_t), 1);
      for (int k = 0; k < 20; k++) begin
        @(posedge clk);
        @(negedge clk);
        n++;
        if (state_t == 4'd8) break;
      end
      checkOutput("to_cycles_to_error", n, 3);
      checkOutput("to_error_flag", int'(error_t), 1);
      checkOutput("to_error_strobes", strobes_t(), 0);
      mem_ready_t = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("to_error_sticky", int'(state_t), 8);
      rst_t = 1'b0;
      #1;
      checkOutput("to_rst_clears_error", int'(error_t), 0);
      checkOutput("to_rst_flags", int'(flags_t), 0);
      mem_ready_t = 1'b0;
      @(negedge clk);
      rst_t = 1'b1;
      @(posedge clk);
      @(negedge clk);
      repeat (2) begin
        @(posedge clk);
        @(negedge clk);
      end
      checkOutput("to_boundary_waiting", int'(state_t), 1);
      mem_ready_t = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checkOutput("to_ready_wins", int'(state_t), 2);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
